// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and types for the VGA raster generator.
//   - Standard 640x480@60 timing (default build) and 800x600@60 timing
//     (alternate builds).
//   - gen_state_t    : generator run state.
//   - raster_flags_t : one delay-line stage {act, hs, vs}, all active-high.
//   - in_window()    : half-open range test used for blanking/sync decode.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // 640x480@60, 25.175 MHz nominal pixel clock
    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FRONT  = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BACK   = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FRONT  = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BACK   = 33;

    // 800x600@60, 40 MHz nominal pixel clock
    localparam int unsigned SVGA800_H_ACTIVE = 800;
    localparam int unsigned SVGA800_H_FRONT  = 40;
    localparam int unsigned SVGA800_H_SYNC   = 128;
    localparam int unsigned SVGA800_H_BACK   = 88;
    localparam int unsigned SVGA800_V_ACTIVE = 600;
    localparam int unsigned SVGA800_V_FRONT  = 1;
    localparam int unsigned SVGA800_V_SYNC   = 4;
    localparam int unsigned SVGA800_V_BACK   = 23;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_t;

    // Internal flags are active-high; polarity is applied only at the pins.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } raster_flags_t;

    localparam raster_flags_t FLAGS_INACTIVE = '0;

    // True when first <= pos < first + len (empty when len == 0).
    function automatic logic in_window(input logic [31:0] pos,
                                       input int unsigned first,
                                       input int unsigned len);
        return (pos >= first) && (pos < first + len);
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// ---------------------------------------------------------------------------
// pix_tick_div
// Divides the system clock down to a pixel-rate clock enable.
//   clk    in  system clock
//   reset  in  asynchronous, active-high
//   p_tick out high for one clk in every CLK_DIV (constantly high when
//              CLK_DIV == 1)
// ---------------------------------------------------------------------------
module pix_tick_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator.
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   enable       in   run request, sampled on p_tick
//   p_tick       out  pixel clock enable
//   pixel_x/y    out  raster counters (undelayed, for pixel addressing)
//   video_on     out  active-area flag, PIPE_DELAY ticks behind the counters
//   hsync/vsync  out  sync pins, same delay, polarity HSYNC_POL/VSYNC_POL
//   line_start   out  one-clk pulse when the counters move to h=0
//   frame_start  out  one-clk pulse when a frame begins at (0,0)
//   frame_count  out  completed-frame counter (wraps)
//   running      out  generator active
// Runs only start and stop on frame boundaries; dropping enable mid-frame
// lets the current frame finish.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int unsigned H_FRONT    = VGA640_H_FRONT,
    parameter int unsigned H_SYNC     = VGA640_H_SYNC,
    parameter int unsigned H_BACK     = VGA640_H_BACK,
    parameter int unsigned V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int unsigned V_FRONT    = VGA640_V_FRONT,
    parameter int unsigned V_SYNC     = VGA640_V_SYNC,
    parameter int unsigned V_BACK     = VGA640_V_BACK,
    parameter int unsigned CLK_DIV    = 2,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned PIPE_DELAY = 2,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [15:0]      frame_count,
    output logic             running
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    gen_state_t       state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done;
    logic [15:0]      frame_count_q;
    logic             h_end, v_end;
    raster_flags_t    raw_flags;
    raster_flags_t    pipe_q [PIPE_DELAY];
    raster_flags_t    pipe_out;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    assign h_end = (h_q == H_LAST);
    assign v_end = (v_q == V_LAST);

    // Next-state / counter logic. Pulses default low, so a pulse raised on
    // a p_tick cycle lasts exactly one clk after the edge.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_done    = 1'b0;

        if (p_tick) begin
            case (state_q)
                ST_IDLE: begin
                    // Counters already sit at (0,0); that is the first pixel.
                    if (enable) begin
                        state_d       = ST_RUN;
                        frame_start_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!h_end) begin
                        h_d = h_q + CNT_W'(1);
                    end else begin
                        h_d = '0;
                        if (!v_end) begin
                            v_d          = v_q + CNT_W'(1);
                            line_start_d = 1'b1;
                        end else begin
                            // Frame boundary: the only place a run may stop.
                            v_d        = '0;
                            frame_done = 1'b1;
                            if (enable) begin
                                line_start_d  = 1'b1;
                                frame_start_d = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            h_q           <= '0;
            v_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            if (frame_done) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    // Undelayed decode of the current position; inactive while idle.
    always_comb begin
        raw_flags = FLAGS_INACTIVE;
        if (state_q == ST_RUN) begin
            raw_flags.act = in_window(32'(h_q), 0, H_ACTIVE) &&
                            in_window(32'(v_q), 0, V_ACTIVE);
            raw_flags.hs  = in_window(32'(h_q), H_ACTIVE + H_FRONT, H_SYNC);
            raw_flags.vs  = in_window(32'(v_q), V_ACTIVE + V_FRONT, V_SYNC);
        end
    end

    // Delay line aligns sync/blanking with the downstream colour pipeline.
    // It keeps shifting while idle so the pins drain to inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this is a short flop chain, not a RAM, so every stage is
            // reset; otherwise stale sync could reach the pins after reset.
            for (int i = 0; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= FLAGS_INACTIVE;
            end
        end else if (p_tick) begin
            pipe_q[0] <= raw_flags;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign pipe_out    = pipe_q[PIPE_DELAY-1];
    assign video_on    = pipe_out.act;
    assign hsync       = pipe_out.hs ^ ~HSYNC_POL;
    assign vsync       = pipe_out.vs ^ ~VSYNC_POL;

    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen, three builds sharing one clock:
//   A: small mode H 8/2/2/2, V 4/1/1/1, CLK_DIV=2, PIPE_DELAY=2, active-low
//   C: same raster, CLK_DIV=1, HSYNC_POL=1
//   W: degenerate 1x1 raster, CLK_DIV=1, used to wrap frame_count
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int H_TOT = 14;
    localparam int V_TOT = 7;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } flags_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic        reset_a, enable_a;
    logic        p_tick_a, video_on_a, hsync_a, vsync_a;
    logic        line_start_a, frame_start_a, running_a;
    logic [3:0]  pixel_x_a, pixel_y_a;
    logic [15:0] frame_count_a;

    // Instance C
    logic        reset_c, enable_c;
    logic        p_tick_c, video_on_c, hsync_c, vsync_c;
    logic        line_start_c, frame_start_c, running_c;
    logic [3:0]  pixel_x_c, pixel_y_c;
    logic [15:0] frame_count_c;

    // Instance W
    logic        reset_w, enable_w;
    logic        p_tick_w, video_on_w, hsync_w, vsync_w;
    logic        line_start_w, frame_start_w, running_w;
    logic [0:0]  pixel_x_w, pixel_y_w;
    logic [15:0] frame_count_w;

    int checks = 0;
    int errors = 0;

    // Reference state for instance A
    int     m_h, m_v, m_run, m_fc;
    bit     m_ls, m_fs;
    flags_t hist0, hist1;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .PIPE_DELAY(2), .CNT_W(4)
    ) dut_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .p_tick(p_tick_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .video_on(video_on_a),
        .hsync(hsync_a), .vsync(vsync_a), .line_start(line_start_a),
        .frame_start(frame_start_a), .frame_count(frame_count_a),
        .running(running_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
        .PIPE_DELAY(2), .CNT_W(4)
    ) dut_c (
        .clk(clk), .reset(reset_c), .enable(enable_c), .p_tick(p_tick_c),
        .pixel_x(pixel_x_c), .pixel_y(pixel_y_c), .video_on(video_on_c),
        .hsync(hsync_c), .vsync(vsync_c), .line_start(line_start_c),
        .frame_start(frame_start_c), .frame_count(frame_count_c),
        .running(running_c)
    );

    vga_timing_gen #(
        .H_ACTIVE(1), .H_FRONT(0), .H_SYNC(0), .H_BACK(0),
        .V_ACTIVE(1), .V_FRONT(0), .V_SYNC(0), .V_BACK(0),
        .CLK_DIV(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .PIPE_DELAY(1), .CNT_W(1)
    ) dut_w (
        .clk(clk), .reset(reset_w), .enable(enable_w), .p_tick(p_tick_w),
        .pixel_x(pixel_x_w), .pixel_y(pixel_y_w), .video_on(video_on_w),
        .hsync(hsync_w), .vsync(vsync_w), .line_start(line_start_w),
        .frame_start(frame_start_w), .frame_count(frame_count_w),
        .running(running_w)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic flags_t raw_a(input int h, input int v, input int run);
        flags_t f;
        f.act = (run != 0) && (h < 8) && (v < 4);
        f.hs  = (run != 0) && (h == 10 || h == 11);
        f.vs  = (run != 0) && (v == 5);
        return f;
    endfunction

    task automatic model_reset_a();
        m_h = 0; m_v = 0; m_run = 0; m_fc = 0;
        m_ls = 1'b0; m_fs = 1'b0;
        hist0 = '0; hist1 = '0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_px"},  32'(pixel_x_a), 0);
        check({tag, "_py"},  32'(pixel_y_a), 0);
        check({tag, "_vid"}, 32'(video_on_a), 0);
        check({tag, "_hs"},  32'(hsync_a), 1);
        check({tag, "_vs"},  32'(vsync_a), 1);
        check({tag, "_ls"},  32'(line_start_a), 0);
        check({tag, "_fs"},  32'(frame_start_a), 0);
        check({tag, "_fc"},  32'(frame_count_a), 0);
        check({tag, "_run"}, 32'(running_a), 0);
    endtask

    // Advance instance A past its next p_tick edge, update the reference,
    // and compare every output. Must be entered away from a clock edge.
    task automatic step_a(input string tag);
        bit pt;
        bit en;
        pt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pt = p_tick_a;
            en = enable_a;
            @(posedge clk);
            #1;
            if (pt) break;
        end
        check({tag, "_tick_timeout"}, 32'(pt), 1);

        hist1 = hist0;
        hist0 = raw_a(m_h, m_v, m_run);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (m_run == 0) begin
            if (en) begin
                m_run = 1;
                m_fs  = 1'b1;
            end
        end else if (m_h != H_TOT - 1) begin
            m_h++;
        end else begin
            m_h = 0;
            if (m_v != V_TOT - 1) begin
                m_v++;
                m_ls = 1'b1;
            end else begin
                m_v  = 0;
                m_fc = (m_fc + 1) & 16'hFFFF;
                if (en) begin
                    m_ls = 1'b1;
                    m_fs = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
        end

        check($sformatf("%s_px@(%0d,%0d)", tag, m_h, m_v), 32'(pixel_x_a), m_h);
        check($sformatf("%s_py@(%0d,%0d)", tag, m_h, m_v), 32'(pixel_y_a), m_v);
        check($sformatf("%s_run@(%0d,%0d)", tag, m_h, m_v), 32'(running_a), m_run);
        check($sformatf("%s_ls@(%0d,%0d)", tag, m_h, m_v), 32'(line_start_a), 32'(m_ls));
        check($sformatf("%s_fs@(%0d,%0d)", tag, m_h, m_v), 32'(frame_start_a), 32'(m_fs));
        check($sformatf("%s_fc@(%0d,%0d)", tag, m_h, m_v), 32'(frame_count_a), m_fc);
        check($sformatf("%s_vid@(%0d,%0d)", tag, m_h, m_v), 32'(video_on_a), 32'(hist1.act));
        check($sformatf("%s_hs@(%0d,%0d)", tag, m_h, m_v), 32'(hsync_a), 32'(!hist1.hs));
        check($sformatf("%s_vs@(%0d,%0d)", tag, m_h, m_v), 32'(vsync_a), 32'(!hist1.vs));
    endtask

    initial begin
        int vid_cnt, fs_cnt, hs_cnt, ex;

        reset_a = 1'b1; reset_c = 1'b1; reset_w = 1'b1;
        enable_a = 1'b0; enable_c = 1'b0; enable_w = 1'b0;
        model_reset_a();
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        check_reset_a("rst");
        check("rst_ptick_a", 32'(p_tick_a), 0);
        check("rst_ptick_c", 32'(p_tick_c), 1);
        check("rst_hs_c", 32'(hsync_c), 0);
        check("rst_vs_c", 32'(vsync_c), 1);
        check("rst_run_w", 32'(running_w), 0);

        @(negedge clk);
        reset_a = 1'b0; reset_c = 1'b0; reset_w = 1'b0;
        enable_a = 1'b1; enable_w = 1'b1;
        #1;
        check("div_ph0", 32'(p_tick_a), 0);
        @(posedge clk);
        #1;
        check("div_ph1", 32'(p_tick_a), 1);
        check("w_start_run", 32'(running_w), 1);
        check("w_start_fs", 32'(frame_start_w), 1);
        check("w_start_fc", 32'(frame_count_w), 0);

        // First p_tick with enable: frame_start, counters stay (0,0)
        step_a("start");
        check("w_fc1", 32'(frame_count_w), 1);
        check("start_ptick_lo", 32'(p_tick_a), 0);
        @(posedge clk);
        #1;
        check("fs_one_clk", 32'(frame_start_a), 0);
        check("start_ptick_hi", 32'(p_tick_a), 1);

        // Two full frames
        for (int f = 0; f < 2; f++) begin
            vid_cnt = 0;
            fs_cnt  = 0;
            for (int k = 0; k < 98; k++) begin
                step_a("run");
                if (video_on_a) vid_cnt++;
                if (frame_start_a) fs_cnt++;
            end
            check($sformatf("vid_per_frame%0d", f), vid_cnt, 32);
            check($sformatf("fs_per_frame%0d", f), fs_cnt, 1);
        end
        check("fc_after2", 32'(frame_count_a), 2);

        // Drop enable at (3,2): frame must still complete
        for (int k = 0; k < 100 && !(m_h == 3 && m_v == 2); k++) step_a("to32");
        check("at32_x", 32'(pixel_x_a), 3);
        enable_a = 1'b0;
        for (int k = 0; k < 100 && m_run != 0; k++) step_a("drain");
        check("stop_run", 32'(running_a), 0);
        check("stop_fc", 32'(frame_count_a), 3);
        check("stop_fs", 32'(frame_start_a), 0);
        for (int k = 0; k < 4; k++) step_a("idle");
        check("idle_vid", 32'(video_on_a), 0);
        check("idle_hs", 32'(hsync_a), 1);
        check("idle_vs", 32'(vsync_a), 1);

        // Restart, then reset mid-frame at (5,3)
        enable_a = 1'b1;
        step_a("restart");
        check("restart_fs", 32'(frame_start_a), 1);
        for (int k = 0; k < 100 && !(m_h == 5 && m_v == 3); k++) step_a("to53");
        check("pre_rst_vid", 32'(video_on_a), 1);
        #2;
        reset_a = 1'b1;
        #1;
        check_reset_a("async_rst");
        @(posedge clk);
        #1;
        check_reset_a("held_rst");
        @(negedge clk);
        reset_a = 1'b0;
        model_reset_a();
        step_a("after_rst");
        check("after_rst_fs", 32'(frame_start_a), 1);
        check("after_rst_x", 32'(pixel_x_a), 0);

        // CLK_DIV=1, active-high hsync
        @(posedge clk);
        #1;
        enable_c = 1'b1;
        @(posedge clk);
        #1;
        check("c_start_run", 32'(running_c), 1);
        check("c_start_fs", 32'(frame_start_c), 1);
        check("c_start_x", 32'(pixel_x_c), 0);
        repeat (16) @(posedge clk);
        #1;
        check("c_x16", 32'(pixel_x_c), 2);
        ex = 2;
        hs_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            ex = (ex + 1) % H_TOT;
            check($sformatf("c_ptick%0d", k), 32'(p_tick_c), 1);
            check($sformatf("c_x%0d", k), 32'(pixel_x_c), ex);
            check($sformatf("c_hs_x%0d", ex), 32'(hsync_c), 32'(ex == 12 || ex == 13));
            if (hsync_c) hs_cnt++;
        end
        check("c_hs_width", hs_cnt, 2);

        // frame_count wrap on the 1x1 raster
        for (int k = 0; k < 70000 && frame_count_w !== 16'hFFFF; k++) begin
            @(posedge clk);
            #1;
        end
        check("w_reach_ffff", 32'(frame_count_w), 32'hFFFF);
        @(posedge clk);
        #1;
        check("w_wrap_fc", 32'(frame_count_w), 0);
        check("w_wrap_fs", 32'(frame_start_w), 1);
        check("w_wrap_run", 32'(running_w), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
